// File: rtl/video_out_pkg.sv
// video_out_pkg: shared types and constants for the video_out display path.
//   fetch_state_t    - states of the Wishbone word-fetch FSM
//   CTR_ENABLE_BIT   - bit of the control register that enables the path
//   WB_SEL_ALL       - byte select for full 32-bit reads
//   words_per_frame  - packed words in one frame (4 pixels per word)
//   WORDS_PER_FRAME  - words_per_frame() at the default 640x480 geometry
package video_out_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } fetch_state_t;

   localparam int         CTR_ENABLE_BIT = 0;
   localparam logic [3:0] WB_SEL_ALL     = 4'hF;

   function automatic int words_per_frame(input int h_active, input int v_active);
      return (h_active * v_active) / 4;
   endfunction

   localparam int WORDS_PER_FRAME = words_per_frame(640, 480);

endpackage

// File: rtl/video_out_fifo.sv
// video_out_fifo: synchronous word FIFO with first-word-fall-through read.
//   clk_i, reset_i  - clock and asynchronous active-high reset
//   push_i/data_i   - write a word (ignored when full)
//   pop_i           - advance past the head word (ignored when empty)
//   flush_i         - empty the FIFO; wins over a same-cycle push/pop
//   rd_data_o       - head word, valid whenever empty_o is low
//   count_o         - words held; empty_o / full_o status flags
module video_out_fifo
   import video_out_pkg::*;
#(
   parameter int DEPTH = 16,
   parameter int WIDTH = 32
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     empty_o,
   output logic                     full_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q;
   logic [AW-1:0]    rd_ptr_q;
   logic [AW:0]      count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o   = (count_q == '0);
   assign full_o    = (count_q == (AW+1)'(DEPTH));
   assign count_o   = count_q;
   assign rd_data_o = mem_q[rd_ptr_q];
   assign do_push   = push_i && !full_o;
   assign do_pop    = pop_i && !empty_o;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else if (flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         unique case ({do_push, do_pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   // Storage needs no reset: pointers and count define what is valid.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
   end

endmodule

// File: rtl/video_out.sv
// video_out: reads a packed 8-bit-per-pixel frame over Wishbone, buffers the
// words and replays them as a line_valid / frame_valid / pixel stream.
//   clk, reset         - system clock, asynchronous active-high reset
//   wb_reg_data        - frame base byte address (latched at frame start)
//   wb_reg_ctr         - control, bit 0 enables the path
//   interrupt          - one-clk pulse at the end of each displayed frame
//   underflow          - sticky starvation flag, cleared at frame start
//   line_valid, frame_valid, pixel_out - registered video outputs
//   p_wb_*             - Wishbone read master (single outstanding access)
//
// Fetch FSM
//   state | meaning
//   IDLE  | waiting for FIFO room / enable / first frame start
//   REQ   | bus read outstanding, STB/CYC held until ACK or ERR
//   DONE  | every word of the frame fetched, wait for frame start
module video_out
   import video_out_pkg::*;
#(
   parameter int H_ACTIVE   = 640,
   parameter int H_BLANK    = 160,
   parameter int V_ACTIVE   = 480,
   parameter int V_BLANK    = 45,
   parameter int CLK_DIV    = 4,
   parameter int FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] wb_reg_data,
   input  logic [31:0] wb_reg_ctr,
   output logic        interrupt,
   output logic        underflow,
   output logic        line_valid,
   output logic        frame_valid,
   output logic [7:0]  pixel_out,
   output logic        p_wb_STB_O,
   output logic        p_wb_CYC_O,
   output logic        p_wb_LOCK_O,
   output logic        p_wb_WE_O,
   output logic [3:0]  p_wb_SEL_O,
   output logic [31:0] p_wb_ADR_O,
   input  logic        p_wb_ACK_I,
   input  logic [31:0] p_wb_DAT_I,
   input  logic        p_wb_ERR_I
);

   localparam int H_TOTAL = H_ACTIVE + H_BLANK;
   localparam int V_TOTAL = V_ACTIVE + V_BLANK;
   localparam int WORDS   = words_per_frame(H_ACTIVE, V_ACTIVE);
   localparam int HW      = $clog2(H_TOTAL + 1);
   localparam int VW      = $clog2(V_TOTAL + 1);
   localparam int DW      = $clog2(CLK_DIV + 1);
   localparam int WCW     = $clog2(WORDS + 1);
   localparam int FCW     = $clog2(FIFO_DEPTH) + 1;

   fetch_state_t   state_q, state_d;
   logic           en_q, first_q;
   logic [DW-1:0]  div_q;
   logic [HW-1:0]  h_q;
   logic [VW-1:0]  v_q;
   logic [31:0]    base_q;
   logic [WCW-1:0] wcnt_q;
   logic [WCW-1:0] drop_q, drop_d;
   logic           group_bad_q, underflow_q, interrupt_q;
   logic           line_valid_q, frame_valid_q;
   logic [7:0]     pixel_q;

   logic           enable, en_rise, tick, frame_start;
   logic           active, group_start, starve, bad_group, pop;
   logic [1:0]     byte_sel;
   logic           bus_done, discard, push, flush;
   logic [31:0]    bus_word, fifo_rd_data;
   logic [FCW-1:0] fifo_count;
   logic           fifo_empty, fifo_full_unused;
   logic           ctr_unused;

   assign ctr_unused  = ^wb_reg_ctr[31:1];
   assign enable      = wb_reg_ctr[CTR_ENABLE_BIT];
   // Timing waits one clk after enable rises so the reload to vblank lands first.
   assign en_rise     = enable && !en_q;
   assign tick        = enable && en_q && (div_q == DW'(CLK_DIV - 1));
   assign frame_start = tick && (h_q == '0) && (v_q == VW'(V_ACTIVE));
   assign active      = (v_q < VW'(V_ACTIVE)) && (h_q < HW'(H_ACTIVE));
   assign byte_sel    = h_q[1:0];
   assign group_start = tick && active && (byte_sel == 2'd0);
   assign starve      = group_start && fifo_empty;
   assign bad_group   = (byte_sel == 2'd0) ? fifo_empty : group_bad_q;
   assign pop         = tick && active && (byte_sel == 2'd3) && !group_bad_q;

   assign bus_done    = (state_q == REQ) && (p_wb_ACK_I || p_wb_ERR_I);
   assign bus_word    = p_wb_ERR_I ? 32'h0 : p_wb_DAT_I;
   // A word landing in the same cycle as a starved group belongs to that group
   // and is too late, so it is dropped just like one owed by drop_q.
   assign discard     = bus_done && ((drop_q != '0) || starve);
   assign push        = bus_done && !discard;
   assign flush       = frame_start || !enable;

   video_out_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (32)
   ) u_fifo (
      .clk_i     (clk),
      .reset_i   (reset),
      .push_i    (push),
      .data_i    (bus_word),
      .pop_i     (pop),
      .flush_i   (flush),
      .rd_data_o (fifo_rd_data),
      .count_o   (fifo_count),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full_unused)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         en_q    <= 1'b0;
         first_q <= 1'b1;
         div_q   <= '0;
         h_q     <= '0;
         v_q     <= '0;
      end else begin
         en_q <= enable;
         if (!enable || en_rise) begin
            div_q   <= '0;
            h_q     <= '0;
            v_q     <= enable ? VW'(V_ACTIVE) : '0;
            first_q <= 1'b1;
         end else begin
            if (frame_start) first_q <= 1'b0;
            if (tick) begin
               div_q <= '0;
               if (h_q == HW'(H_TOTAL - 1)) begin
                  h_q <= '0;
                  v_q <= (v_q == VW'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
               end else begin
                  h_q <= h_q + 1'b1;
               end
            end else begin
               div_q <= div_q + 1'b1;
            end
         end
      end
   end

   always_comb begin
      drop_d = drop_q;
      if (flush) begin
         drop_d = '0;
      end else if (starve && !bus_done) begin
         drop_d = drop_q + 1'b1;
      end else if (!starve && bus_done && (drop_q != '0)) begin
         drop_d = drop_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q      <= '0;
         wcnt_q      <= '0;
         drop_q      <= '0;
         underflow_q <= 1'b0;
         group_bad_q <= 1'b0;
      end else begin
         drop_q <= drop_d;
         if (frame_start) begin
            base_q      <= wb_reg_data;
            wcnt_q      <= '0;
            underflow_q <= 1'b0;
         end else begin
            if (bus_done) wcnt_q <= wcnt_q + 1'b1;
            if (starve)   underflow_q <= 1'b1;
         end
         if (!enable)          group_bad_q <= 1'b0;
         else if (group_start) group_bad_q <= fifo_empty;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         interrupt_q   <= 1'b0;
         line_valid_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         pixel_q       <= '0;
      end else if (!enable) begin
         interrupt_q   <= 1'b0;
         line_valid_q  <= 1'b0;
         frame_valid_q <= 1'b0;
         pixel_q       <= '0;
      end else begin
         interrupt_q <= frame_start && !first_q;
         if (tick) begin
            frame_valid_q <= (v_q < VW'(V_ACTIVE));
            line_valid_q  <= active;
            pixel_q       <= (active && !bad_group) ? fifo_rd_data[{byte_sel, 3'b000} +: 8] : 8'h00;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            // Words counted before a same-cycle frame start belong to the old frame.
            if (!frame_start && (wcnt_q == WCW'(WORDS))) begin
               state_d = DONE;
            end else if (enable && !first_q && (fifo_count < FCW'(FIFO_DEPTH))) begin
               state_d = REQ;
            end
         end
         REQ:     if (bus_done) state_d = IDLE;
         DONE:    if (frame_start) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   assign interrupt   = interrupt_q;
   assign underflow   = underflow_q;
   assign line_valid  = line_valid_q;
   assign frame_valid = frame_valid_q;
   assign pixel_out   = pixel_q;
   assign p_wb_STB_O  = (state_q == REQ);
   assign p_wb_CYC_O  = (state_q == REQ);
   assign p_wb_LOCK_O = 1'b0;
   assign p_wb_WE_O   = 1'b0;
   assign p_wb_SEL_O  = WB_SEL_ALL;
   assign p_wb_ADR_O  = base_q + 32'({wcnt_q, 2'b00});

endmodule

// File: tb/tb_video_out.sv
module tb_video_out;

   localparam int H_ACTIVE = 8, H_BLANK = 4, V_ACTIVE = 2, V_BLANK = 2;
   localparam int CLK_DIV = 1, FIFO_DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] wb_reg_data;
   logic [31:0] wb_reg_ctr;
   logic        interrupt, underflow, line_valid, frame_valid;
   logic [7:0]  pixel_out;
   logic        p_wb_STB_O, p_wb_CYC_O, p_wb_LOCK_O, p_wb_WE_O;
   logic [3:0]  p_wb_SEL_O;
   logic [31:0] p_wb_ADR_O;
   logic        p_wb_ACK_I;
   logic [31:0] p_wb_DAT_I;
   logic        p_wb_ERR_I;

   always #5 clk = ~clk;

   video_out #(
      .H_ACTIVE(H_ACTIVE), .H_BLANK(H_BLANK), .V_ACTIVE(V_ACTIVE),
      .V_BLANK(V_BLANK), .CLK_DIV(CLK_DIV), .FIFO_DEPTH(FIFO_DEPTH)
   ) dut (
      .clk(clk), .reset(reset), .wb_reg_data(wb_reg_data), .wb_reg_ctr(wb_reg_ctr),
      .interrupt(interrupt), .underflow(underflow), .line_valid(line_valid),
      .frame_valid(frame_valid), .pixel_out(pixel_out),
      .p_wb_STB_O(p_wb_STB_O), .p_wb_CYC_O(p_wb_CYC_O), .p_wb_LOCK_O(p_wb_LOCK_O),
      .p_wb_WE_O(p_wb_WE_O), .p_wb_SEL_O(p_wb_SEL_O), .p_wb_ADR_O(p_wb_ADR_O),
      .p_wb_ACK_I(p_wb_ACK_I), .p_wb_DAT_I(p_wb_DAT_I), .p_wb_ERR_I(p_wb_ERR_I)
   );

   int          n_vec = 0;
   int          n_err = 0;
   logic [7:0]  pix_q[$];
   logic [31:0] addr_q[$];
   logic        mon_en = 1'b0;
   int          run_len = 0;
   int          irq_cnt = 0;
   int          resp_delay = 0;
   int          resp_wait = 0;
   int          err_word = -1;
   logic        withhold_w2 = 1'b0;
   int          acks_issued = 0;
   logic [31:0] held_adr = '0;
   logic [31:0] base = 32'h1000;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: monitor video outputs against the scoreboard, then act as the
   // Wishbone slave for the next rising edge.
   task automatic step();
      logic [31:0] off;
      logic [7:0]  b;
      int          idx;
      @(negedge clk);
      if (mon_en) begin
         if (line_valid === 1'b1) begin
            run_len++;
            check("frame_valid_in_line", frame_valid, 1);
            if (pix_q.size() == 0) check("pixel_expected", 32'(pix_q.size()), 1);
            else                   check("pixel", pixel_out, pix_q.pop_front());
         end else begin
            check("pixel_idle_zero", pixel_out, 0);
            if (run_len != 0) begin
               check("line_len", run_len, H_ACTIVE);
               run_len = 0;
            end
         end
         if (interrupt === 1'b1) irq_cnt++;
      end else begin
         run_len = 0;
      end

      if (withhold_w2 && underflow === 1'b1) withhold_w2 = 1'b0;
      if (p_wb_ACK_I || p_wb_ERR_I) begin
         p_wb_ACK_I = 1'b0;
         p_wb_ERR_I = 1'b0;
      end else if (p_wb_STB_O === 1'b1) begin
         off = p_wb_ADR_O - base;
         idx = int'(off[31:2]);
         if (resp_wait > 0) check("adr_stable", p_wb_ADR_O, held_adr);
         held_adr = p_wb_ADR_O;
         if (withhold_w2 && idx == 2) begin
            resp_wait = 1;
         end else if (resp_wait < resp_delay) begin
            resp_wait++;
         end else begin
            if (addr_q.size() != 0) check("adr", p_wb_ADR_O, addr_q.pop_front());
            b = 8'(idx * 4);
            p_wb_DAT_I = {b + 8'd3, b + 8'd2, b + 8'd1, b};
            p_wb_ACK_I = 1'b1;
            p_wb_ERR_I = (idx == err_word);
            resp_wait  = 0;
            acks_issued++;
         end
      end else if (resp_wait != 0) begin
         check("stb_held", p_wb_STB_O, 1);
         resp_wait = 0;
      end
   endtask

   task automatic restart(input int delay, input int errw, input logic hold);
      int k;
      mon_en      = 1'b0;
      withhold_w2 = 1'b0;
      wb_reg_ctr  = 32'h0;
      k = 0;
      while (p_wb_STB_O === 1'b1 && k < 40) begin step(); k++; end
      step(); step();
      pix_q.delete();
      addr_q.delete();
      irq_cnt     = 0;
      resp_delay  = delay;
      err_word    = errw;
      withhold_w2 = hold;
      wb_reg_data = base;
   endtask

   task automatic run_frame_test(input int delay, input int errw, input logic hold, input int zero_group);
      int   k;
      logic found;
      restart(delay, errw, hold);
      for (int i = 0; i < 4; i++) addr_q.push_back(base + 32'(4 * i));
      for (int i = 0; i < 16; i++) pix_q.push_back((i / 4 == zero_group) ? 8'h00 : 8'(i));
      mon_en     = 1'b1;
      wb_reg_ctr = 32'h1;
      k = 0;
      while ((pix_q.size() != 0 || run_len != 0) && k < 300) begin step(); k++; end
      check("drain", 32'(pix_q.size()), 0);
      check("underflow_in_frame", underflow, hold ? 1 : 0);
      check("addr_all_seen", 32'(addr_q.size()), 0);
      found = 1'b0;
      k = 0;
      while (!found && k < 100) begin
         step();
         if (interrupt === 1'b1) found = 1'b1;
         k++;
      end
      check("irq_seen", found, 1);
      check("irq_count", irq_cnt, 1);
      check("underflow_at_frame_start", underflow, 0);
      step();
      check("irq_pulse_width", interrupt, 0);
      mon_en = 1'b0;
   endtask

   task automatic wait_window(output logic found);
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         step();
         if (line_valid === 1'b1 && p_wb_STB_O === 1'b1 && p_wb_ACK_I === 1'b0 &&
             resp_wait < resp_delay - 2) found = 1'b1;
      end
   endtask

   initial begin
      logic found;
      int   n0, k;
      reset       = 1'b1;
      wb_reg_data = 32'h0;
      wb_reg_ctr  = 32'h0;
      p_wb_ACK_I  = 1'b0;
      p_wb_ERR_I  = 1'b0;
      p_wb_DAT_I  = 32'h0;
      step(); step(); step();
      check("rst_stb", p_wb_STB_O, 0);
      check("rst_cyc", p_wb_CYC_O, 0);
      check("rst_lv", line_valid, 0);
      check("rst_fv", frame_valid, 0);
      check("rst_pix", pixel_out, 0);
      check("rst_irq", interrupt, 0);
      check("rst_uf", underflow, 0);
      check("rst_adr", p_wb_ADR_O, 0);
      check("we_low", p_wb_WE_O, 0);
      check("lock_low", p_wb_LOCK_O, 0);
      check("sel_all", p_wb_SEL_O, 4'hF);
      reset = 1'b0;
      step();

      // zero-wait, delayed ACK, ERR on word 1, late word 2
      run_frame_test(0, -1, 1'b0, -1);
      run_frame_test(3, -1, 1'b0, -1);
      run_frame_test(0, 1, 1'b0, 1);
      run_frame_test(0, -1, 1'b1, 2);

      // disable while a read is outstanding
      restart(8, -1, 1'b0);
      wb_reg_ctr = 32'h1;
      wait_window(found);
      check("disable_window", found, 1);
      wb_reg_ctr = 32'h0;
      n0 = acks_issued;
      step();
      check("dis_fv", frame_valid, 0);
      check("dis_lv", line_valid, 0);
      check("dis_pix", pixel_out, 0);
      check("dis_cyc_held", p_wb_CYC_O, 1);
      k = 0;
      while (acks_issued == n0 && k < 20) begin
         check("dis_cyc_wait", p_wb_CYC_O, 1);
         step();
         k++;
      end
      check("dis_ack_given", acks_issued - n0, 1);
      step();
      check("dis_cyc_drop", p_wb_CYC_O, 0);
      check("dis_stb_drop", p_wb_STB_O, 0);
      for (int i = 0; i < 3; i++) begin
         step();
         check("dis_blocked", p_wb_STB_O, 0);
      end

      // re-enable restarts from vblank at the base address
      run_frame_test(0, -1, 1'b0, -1);

      // reset in the middle of an outstanding read during active video
      restart(8, -1, 1'b0);
      wb_reg_ctr = 32'h1;
      wait_window(found);
      check("reset_window", found, 1);
      #2;
      reset = 1'b1;
      #1;
      check("mid_rst_stb", p_wb_STB_O, 0);
      check("mid_rst_cyc", p_wb_CYC_O, 0);
      check("mid_rst_lv", line_valid, 0);
      check("mid_rst_fv", frame_valid, 0);
      check("mid_rst_pix", pixel_out, 0);
      check("mid_rst_irq", interrupt, 0);
      check("mid_rst_adr", p_wb_ADR_O, 0);
      p_wb_ACK_I = 1'b0;
      p_wb_ERR_I = 1'b0;
      resp_wait  = 0;
      wb_reg_ctr = 32'h0;
      step(); step();
      reset = 1'b0;
      step();
      check("post_rst_stb", p_wb_STB_O, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/video_out.md
Name: video_out

Overview:
- Display-side counterpart of the camera capture path. Reads a packed 8-bit-per-pixel frame from RAM as a Wishbone master.
- Buffers the words in a small FIFO and unpacks each 32-bit word into 4 pixels.
- Regenerates the line_valid / frame_valid / pixel stream at the pixel rate.
- Sits between the Wishbone bus (frame base and control come from the slave register block) and the video output pins.

Parameters:
- H_ACTIVE, 640, active pixels per line (multiple of 4)
- H_BLANK, 160, blank pixel ticks per line
- V_ACTIVE, 480, active lines per frame
- V_BLANK, 45, blank lines per frame
- CLK_DIV, 4, system clocks per pixel tick (>=1)
- FIFO_DEPTH, 16, word FIFO depth (power of 2, >=4)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous reset, active-high
- wb_reg_data  in  32  frame base byte address (word aligned)
- wb_reg_ctr  in  32  control; bit0 = enable, other bits ignored
- interrupt  out  1  one-clk pulse at end of each displayed frame
- underflow  out  1  sticky: FIFO empty when a word was needed; cleared at frame start
- line_valid  out  1  active pixel on pixel_out
- frame_valid  out  1  active frame
- pixel_out  out  8  pixel data
- p_wb_STB_O  out  1  strobe
- p_wb_CYC_O  out  1  cycle
- p_wb_LOCK_O  out  1  always 0
- p_wb_WE_O  out  1  always 0 (reads only)
- p_wb_SEL_O  out  4  always 4'hF
- p_wb_ADR_O  out  32  read byte address
- p_wb_ACK_I  in  1  acknowledge
- p_wb_DAT_I  in  32  read data
- p_wb_ERR_I  in  1  bus error

Behaviour:
- Reset: every output 0; counters, FIFO, drop counter and fetch FSM cleared; FSM in IDLE.
- Pixel tick: divider counts 0..CLK_DIV-1 and ticks on CLK_DIV-1. Divider runs only while enable=1; otherwise it is held at 0.
- Timing: h_cnt 0..H_ACTIVE+H_BLANK-1 and v_cnt 0..V_ACTIVE+V_BLANK-1 advance on ticks.
  - Active lines are v<V_ACTIVE. Blank lines follow.
  - On enable rising, timing loads h=0, v=V_ACTIVE (start of vblank) so the FIFO prefills before the first line.
- Frame start event: tick with h=0, v=V_ACTIVE. On this event:
  - latch base from wb_reg_data
  - word counter := 0
  - flush FIFO and drop counter (event has priority over a same-cycle push)
  - clear underflow
  - interrupt=1 for exactly one clk (suppressed on the very first event after enable)
- Outputs are registered, updated on ticks:
  - frame_valid=1 while v<V_ACTIVE, including hblank.
  - line_valid=1 while v<V_ACTIVE and h<H_ACTIVE.
  - pixel_out is valid in the same cycle as line_valid and is 0 when line_valid=0.
- Unpack: byte_sel = h[1:0]. Output order per word is [7:0], [15:8], [23:16], [31:24]. The word is popped at byte_sel=3.
- Underflow: FIFO empty at a byte_sel=0 active tick ->
  - underflow:=1
  - pixels for that 4-pixel group output as 0
  - drop_cnt++
  - Next arriving words are discarded while drop_cnt>0 (drop_cnt-- per discarded word), so later pixels keep correct alignment.
- Fetch FSM, states IDLE, REQ, DONE:
  - IDLE: go to REQ when enable=1, word counter < H_ACTIVE*V_ACTIVE/4, and FIFO count < FIFO_DEPTH.
  - REQ: STB=CYC=1 with ADR = base + 4*word counter, held stable until ACK or ERR.
  - ACK: push DAT_I (or discard if drop_cnt>0), word counter++, go to IDLE.
  - ERR: push 32'h0 instead of data, otherwise same as ACK. ERR wins if ACK and ERR are asserted in the same cycle.
  - STB/CYC drop the cycle after ACK/ERR (no back-to-back pipelining).
  - IDLE goes to DONE when all words are fetched. DONE returns to IDLE on frame start.
- FIFO push and pop in the same cycle is legal; count is unchanged. Push is never issued when the FIFO is full.
- Disable mid-frame:
  - timing, outputs and interrupt go to 0 on the next clk
  - an outstanding REQ keeps STB/CYC until ACK/ERR, then drops
  - FIFO is flushed and new requests are blocked
- Reset mid-cycle drops STB/CYC immediately.
- Word counter width: $clog2(H_ACTIVE*V_ACTIVE/4 + 1). Address arithmetic is 32-bit and wraps modulo 2^32.

Decomposition:
- Package video_out_pkg holds:
  - fetch_state_t enum (IDLE, REQ, DONE)
  - CTR_ENABLE_BIT = 0
  - WB_SEL_ALL = 4'hF
  - derived constant WORDS_PER_FRAME
- Sub-module video_out_fifo: synchronous word FIFO with push, pop, flush, count, empty and full; first-word-fall-through read.

Test Plan:
Benches use H_ACTIVE=8, H_BLANK=4, V_ACTIVE=2, V_BLANK=2, CLK_DIV=1, FIFO_DEPTH=4. Memory returns word i as {4i+3, 4i+2, 4i+1, 4i}.
- Reset asserted mid-operation -> all outputs 0 within one clk; STB/CYC=0.
- Enable with base 0x1000, zero-wait ACK -> addresses 0x1000, 0x1004, 0x1008, 0x100C; pixels 0x00..0x0F in order across 2 lines of 8; line_valid in 8-tick bursts; interrupt single pulse at second frame start.
- ACK delayed 3 clks each -> identical pixel stream; ADR/STB stable while waiting.
- ERR on word 1 (ACK also high) -> pixels 4..7 = 0, all others intact, underflow=0.
- ACK withheld so word 2 is late -> underflow=1; pixels 8..11 = 0; late word 2 discarded; pixels 12..15 correct; underflow cleared at next frame start.
- Disable while STB outstanding -> CYC held until ACK, then 0; frame_valid/line_valid 0 next clk; re-enable restarts from vblank with address 0x1000.
